// File: rtl/ray_setup_gen.sv
// Per-frame ray setup: snapshots the player pose on frame_start_in, then
// walks the screen columns and hands one ray per column to the DDA stage
// over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for frame_start_in; pose snapshot taken on accept
//   CALC  | one cycle: compute ray direction for the current column
//   EMIT  | ray presented; hold until ray_ready_in, then advance or finish
//   DONE  | one-cycle frame_done_out pulse, then back to IDLE
module ray_setup_gen #(
  parameter int SCREEN_WIDTH = 320,
  parameter int CAM_STEP     = 410,
  localparam int COL_W = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  input  logic [15:0]      posX_in,
  input  logic [15:0]      posY_in,
  input  logic [15:0]      dirX_in,
  input  logic [15:0]      dirY_in,
  input  logic [15:0]      planeX_in,
  input  logic [15:0]      planeY_in,
  output logic             ray_valid_out,
  input  logic             ray_ready_in,
  output logic [COL_W-1:0] ray_col_out,
  output logic [15:0]      rayPosX_out,
  output logic [15:0]      rayPosY_out,
  output logic [15:0]      rayDirX_out,
  output logic [15:0]      rayDirY_out,
  output logic             busy_out,
  output logic             frame_done_out
);

  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [23:0]      CAM_STEP_W = 24'(CAM_STEP);
  // cameraX starts at -1.0 in Q8.16
  localparam logic [23:0]      CAM_START  = 24'hFF0000;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [23:0]      cam_acc_q, cam_acc_d;
  logic [15:0]      posx_s_q, posx_s_d, posy_s_q, posy_s_d;
  logic [15:0]      dirx_s_q, dirx_s_d, diry_s_q, diry_s_d;
  logic [15:0]      planex_s_q, planex_s_d, planey_s_q, planey_s_d;
  logic             valid_q, valid_d;
  logic [COL_W-1:0] ray_col_q, ray_col_d;
  logic [15:0]      rposx_q, rposx_d, rposy_q, rposy_d;
  logic [15:0]      rdirx_q, rdirx_d, rdiry_q, rdiry_d;

  logic signed [15:0] cam;
  logic signed [31:0] prod_x, prod_y;
  logic               unused_bits;

  // cameraX in Q8.8; dropping the low byte of Q8.16 floors toward -inf
  assign cam    = signed'(cam_acc_q[23:8]);
  assign prod_x = signed'(planex_s_q) * cam;
  assign prod_y = signed'(planey_s_q) * cam;
  assign unused_bits = ^{cam_acc_q[7:0], prod_x[31:24], prod_x[7:0],
                         prod_y[31:24], prod_y[7:0]};

  // Next-state and datapath update; everything holds unless a state acts
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cam_acc_d  = cam_acc_q;
    posx_s_d   = posx_s_q;
    posy_s_d   = posy_s_q;
    dirx_s_d   = dirx_s_q;
    diry_s_d   = diry_s_q;
    planex_s_d = planex_s_q;
    planey_s_d = planey_s_q;
    valid_d    = valid_q;
    ray_col_d  = ray_col_q;
    rposx_d    = rposx_q;
    rposy_d    = rposy_q;
    rdirx_d    = rdirx_q;
    rdiry_d    = rdiry_q;
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          posx_s_d   = posX_in;
          posy_s_d   = posY_in;
          dirx_s_d   = dirX_in;
          diry_s_d   = dirY_in;
          planex_s_d = planeX_in;
          planey_s_d = planeY_in;
          col_d      = '0;
          cam_acc_d  = CAM_START;
          state_d    = CALC;
        end
      end
      CALC: begin
        rdirx_d   = dirx_s_q + prod_x[23:8];
        rdiry_d   = diry_s_q + prod_y[23:8];
        rposx_d   = posx_s_q;
        rposy_d   = posy_s_q;
        ray_col_d = col_q;
        valid_d   = 1'b1;
        state_d   = EMIT;
      end
      EMIT: begin
        if (ray_ready_in) begin
          valid_d = 1'b0;
          if (col_q == LAST_COL) begin
            state_d = DONE;
          end else begin
            col_d     = col_q + 1'b1;
            cam_acc_d = cam_acc_q + CAM_STEP_W;
            state_d   = CALC;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting a frame
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      col_q      <= '0;
      cam_acc_q  <= '0;
      posx_s_q   <= '0;
      posy_s_q   <= '0;
      dirx_s_q   <= '0;
      diry_s_q   <= '0;
      planex_s_q <= '0;
      planey_s_q <= '0;
      valid_q    <= 1'b0;
      ray_col_q  <= '0;
      rposx_q    <= '0;
      rposy_q    <= '0;
      rdirx_q    <= '0;
      rdiry_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cam_acc_q  <= cam_acc_d;
      posx_s_q   <= posx_s_d;
      posy_s_q   <= posy_s_d;
      dirx_s_q   <= dirx_s_d;
      diry_s_q   <= diry_s_d;
      planex_s_q <= planex_s_d;
      planey_s_q <= planey_s_d;
      valid_q    <= valid_d;
      ray_col_q  <= ray_col_d;
      rposx_q    <= rposx_d;
      rposy_q    <= rposy_d;
      rdirx_q    <= rdirx_d;
      rdiry_q    <= rdiry_d;
    end
  end

  assign ray_valid_out  = valid_q;
  assign ray_col_out    = ray_col_q;
  assign rayPosX_out    = rposx_q;
  assign rayPosY_out    = rposy_q;
  assign rayDirX_out    = rdirx_q;
  assign rayDirY_out    = rdiry_q;
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = (state_q == DONE);

endmodule

// File: tb/tb_ray_setup_gen.sv
// Bench for ray_setup_gen: table of whole-frame scenarios, hand-written
// corner sequences (snapshot/ignore, mid-frame reset) and random frames,
// all checked against an arithmetic cameraX model.
module tb_ray_setup_gen;
  localparam int SW = 320;
  localparam int CS = 410;
  localparam int CW = $clog2(SW);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic [15:0]   posX_in = '0, posY_in = '0, dirX_in = '0, dirY_in = '0;
  logic [15:0]   planeX_in = '0, planeY_in = '0;
  logic          ray_ready_in = 1'b0;
  logic          ray_valid_out;
  logic [CW-1:0] ray_col_out;
  logic [15:0]   rayPosX_out, rayPosY_out, rayDirX_out, rayDirY_out;
  logic          busy_out, frame_done_out;

  ray_setup_gen #(.SCREEN_WIDTH(SW), .CAM_STEP(CS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .posX_in(posX_in), .posY_in(posY_in), .dirX_in(dirX_in), .dirY_in(dirY_in),
    .planeX_in(planeX_in), .planeY_in(planeY_in),
    .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready_in),
    .ray_col_out(ray_col_out), .rayPosX_out(rayPosX_out), .rayPosY_out(rayPosY_out),
    .rayDirX_out(rayDirX_out), .rayDirY_out(rayDirY_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cameraX = -1 + col*step (Q8.16), floored to Q8.8, times plane, floored, plus dir
  function automatic logic [15:0] model_dir(input logic [15:0] d, input logic [15:0] p, input int col);
    int acc, cam, prod;
    acc  = -65536 + col * CS;
    cam  = acc >>> 8;
    prod = int'($signed(p)) * cam;
    return 16'(int'(d) + (prod >>> 8));
  endfunction

  // results captured by run_frame
  logic [15:0] cap_dx[SW], cap_dy[SW], cap_px[SW], cap_py[SW];
  int r_hs, r_done_cyc, r_done_cnt, r_seq_err, r_busy_drop;

  // mode: 0 ready high, 1 stall 5 cycles at col 10, 2 mid-frame dir change
  // and ignored frame_start, 3 reset at col 200, 4 random ready
  task automatic run_frame(input logic [15:0] px, py, dx, dy, plx, ply, input int mode);
    int cyc, stall, exp_col;
    logic [63:0] held_a, held_b;
    cyc = 0; stall = 0; exp_col = 0;
    held_a = '0; held_b = '0;
    r_hs = 0; r_done_cyc = -1; r_done_cnt = 0; r_seq_err = 0; r_busy_drop = 0;
    @(negedge clk_in);
    posX_in = px; posY_in = py; dirX_in = dx; dirY_in = dy;
    planeX_in = plx; planeY_in = ply;
    frame_start_in = 1'b1; ray_ready_in = 1'b1;
    @(negedge clk_in);
    cyc = 1;
    while (cyc < 4 * SW + 50) begin
      frame_start_in = 1'b0;
      if (frame_done_out) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (r_done_cyc < 0 && !busy_out) r_busy_drop++;
      if (r_done_cyc >= 0 && cyc > r_done_cyc + 3) break;
      ray_ready_in = (mode == 4) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ray_valid_out) begin
        if (mode == 3 && int'(ray_col_out) == 200) begin
          ray_ready_in = 1'b0;
          #2 rst_in = 1'b0;
          #1;
          check("abort_valid", 64'(ray_valid_out), 64'd0);
          check("abort_dir", {32'd0, rayDirX_out, rayDirY_out}, 64'd0);
          check("abort_pos_col", {23'd0, ray_col_out, rayPosX_out, rayPosY_out}, 64'd0);
          check("abort_busy", 64'(busy_out), 64'd0);
          for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("abort_no_done", {62'd0, frame_done_out, ray_valid_out}, 64'd0);
          end
          rst_in = 1'b1;
          return;
        end
        if (mode == 1 && int'(ray_col_out) == 10 && stall < 5) begin
          ray_ready_in = 1'b0;
          if (stall == 0) begin
            held_a = {31'd0, ray_valid_out, rayDirX_out, rayDirY_out};
            held_b = {23'd0, ray_col_out, rayPosX_out, rayPosY_out};
          end else begin
            check("bp_stable_dir", {31'd0, ray_valid_out, rayDirX_out, rayDirY_out}, held_a);
            check("bp_stable_pos", {23'd0, ray_col_out, rayPosX_out, rayPosY_out}, held_b);
          end
          stall++;
        end
        if (ray_ready_in) begin
          if (r_hs < SW) begin
            cap_dx[r_hs] = rayDirX_out; cap_dy[r_hs] = rayDirY_out;
            cap_px[r_hs] = rayPosX_out; cap_py[r_hs] = rayPosY_out;
          end
          if (int'(ray_col_out) != exp_col) r_seq_err++;
          exp_col++;
          r_hs++;
        end
        if (mode == 2 && int'(ray_col_out) == 50) dirX_in = 16'h0100;
        if (mode == 2 && int'(ray_col_out) == 100) frame_start_in = 1'b1;
      end
      @(negedge clk_in);
      cyc++;
    end
    frame_start_in = 1'b0;
    ray_ready_in = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] px, py, dx, dy, plx, ply);
    check({tag, "_handshakes"}, 64'(r_hs), 64'(SW));
    check({tag, "_col_seq"}, 64'(r_seq_err), 64'd0);
    check({tag, "_done_pulses"}, 64'(r_done_cnt), 64'd1);
    if (r_hs == SW) begin
      for (int c = 0; c < SW; c++) begin
        check($sformatf("%s_dir_c%0d", tag, c), {32'd0, cap_dx[c], cap_dy[c]},
              {32'd0, model_dir(dx, plx, c), model_dir(dy, ply, c)});
        check($sformatf("%s_pos_c%0d", tag, c), {32'd0, cap_px[c], cap_py[c]}, {32'd0, px, py});
      end
    end
  endtask

  typedef struct {
    logic [15:0] px, py, dx, dy, plx, ply;
    int          mode;
    int          col;
    logic [15:0] exp_dx, exp_dy;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 0, 0,   16'hFF57, 16'hFF00, 641};
    vecs[1] = '{16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 0, 160, 16'h0000, 16'hFF00, 641};
    vecs[2] = '{16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 0, 319, 16'h00A7, 16'hFF00, 641};
    vecs[3] = '{16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 1, 10,  16'hFF61, 16'hFF00, 646};
    vecs[4] = '{16'h0C80, 16'h0C80, 16'h0100, 16'hFF00, 16'h00A9, 16'h0000, 0, 0,   16'h0057, 16'hFF00, 641};
    vecs[5] = '{16'h0200, 16'h0300, 16'h0100, 16'h0000, 16'hFF57, 16'h0040, 0, 0,   16'h01A9, 16'hFFC0, 641};

    // reset state
    repeat (3) @(negedge clk_in);
    check("rst_valid_busy_done", {61'd0, ray_valid_out, busy_out, frame_done_out}, 64'd0);
    check("rst_dir", {32'd0, rayDirX_out, rayDirY_out}, 64'd0);
    check("rst_pos_col", {23'd0, ray_col_out, rayPosX_out, rayPosY_out}, 64'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].px, vecs[i].py, vecs[i].dx, vecs[i].dy, vecs[i].plx, vecs[i].ply, vecs[i].mode);
      check($sformatf("vec%0d_done_cycle", i), 64'(r_done_cyc), 64'(vecs[i].exp_done));
      check($sformatf("vec%0d_busy_gap", i), 64'(r_busy_drop), 64'd0);
      check($sformatf("vec%0d_col%0d_dir", i, vecs[i].col),
            {32'd0, cap_dx[vecs[i].col], cap_dy[vecs[i].col]},
            {32'd0, vecs[i].exp_dx, vecs[i].exp_dy});
      check($sformatf("vec%0d_col%0d_pos", i, vecs[i].col),
            {32'd0, cap_px[vecs[i].col], cap_py[vecs[i].col]},
            {32'd0, vecs[i].px, vecs[i].py});
      check_frame($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].dx,
                  vecs[i].dy, vecs[i].plx, vecs[i].ply);
    end

    // snapshot: dir change at col 50 and frame_start at col 100 are ignored
    run_frame(16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 2);
    check("snap_done_cycle", 64'(r_done_cyc), 64'd641);
    check("snap_busy_gap", 64'(r_busy_drop), 64'd0);
    check("snap_idle_after", {62'd0, busy_out, ray_valid_out}, 64'd0);
    check_frame("snap", 16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000);
    run_frame(16'h0C80, 16'h0C80, 16'h0100, 16'hFF00, 16'h00A9, 16'h0000, 0);
    check("snap_next_col0_dirx", 64'(cap_dx[0]), 64'h0057);

    // mid-frame reset with ready low, then a clean restart from col 0
    run_frame(16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 3);
    check("abort_seen_200_rays", 64'(r_hs), 64'd200);
    repeat (2) @(negedge clk_in);
    run_frame(16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000, 0);
    check("restart_done_cycle", 64'(r_done_cyc), 64'd641);
    check("restart_col0_dir", {32'd0, cap_dx[0], cap_dy[0]}, {32'd0, 16'hFF57, 16'hFF00});
    check_frame("restart", 16'h0C80, 16'h0C80, 16'h0000, 16'hFF00, 16'h00A9, 16'h0000);

    // random poses with random backpressure
    for (int f = 0; f < 4; f++) begin
      logic [15:0] rp[6];
      for (int k = 0; k < 6; k++) rp[k] = 16'($urandom);
      run_frame(rp[0], rp[1], rp[2], rp[3], rp[4], rp[5], 4);
      check_frame($sformatf("rand%0d", f), rp[0], rp[1], rp[2], rp[3], rp[4], rp[5]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
